// File: rtl/mux_stream_rr.sv
// mux_stream_rr: registered CH-way stream multiplexer with valid/ready handshakes.
// Mode 0 forwards the channel named by `select`; mode 1 arbitrates round-robin
// starting after the most recently granted channel. A single output slot gives
// one-cycle latency and full throughput when the consumer drains and refills
// in the same cycle.
module mux_stream_rr #(
  parameter int unsigned N    = 4,
  parameter int unsigned CH   = 8,
  parameter int unsigned SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH*N-1:0]   d,
  input  logic [CH-1:0]     valid_in,
  output logic [CH-1:0]     ready_in,
  input  logic              mode,
  input  logic [SELW-1:0]   select,
  output logic [N-1:0]      exit,
  output logic              exit_valid,
  input  logic              exit_ready,
  output logic [SELW-1:0]   exit_ch
);

  localparam int unsigned SW1 = SELW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e           slot_q, slot_d;
  logic [N-1:0]    exit_q, exit_d;
  logic [SELW-1:0] exit_ch_q, exit_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load;
  logic            accept;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic [N-1:0]    grant_data;
  logic [SW1-1:0]  rr_sum;

  // Grant selection: fixed select in mode 0, first valid channel after ptr in mode 1.
  // The round-robin index is kept one bit wider so ptr+i (< 2*CH) can be
  // wrapped by a single subtract, which also works for non-power-of-two CH.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    if (!mode) begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (select == SELW'(k) && valid_in[k]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(k);
        end
      end
    end else begin
      for (int unsigned i = 1; i <= CH; i++) begin
        rr_sum = {1'b0, ptr_q} + SW1'(i);
        if (rr_sum >= SW1'(CH)) begin
          rr_sum = rr_sum - SW1'(CH);
        end
        if (!grant_valid && valid_in[rr_sum[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_sum[SELW-1:0];
        end
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (grant_idx == SELW'(k)) begin
        grant_data = d[k*N +: N];
      end
    end
  end

  // Handshake: slot can load when empty or draining; ready goes to the granted channel only.
  always_comb begin
    load     = (slot_q == EMPTY) || exit_ready;
    accept   = load && grant_valid && !reset;
    ready_in = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      ready_in[k] = accept && (grant_idx == SELW'(k));
    end
  end

  // Next-state for the output slot and round-robin pointer.
  always_comb begin
    slot_d    = slot_q;
    exit_d    = exit_q;
    exit_ch_d = exit_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      slot_d    = FULL;
      exit_d    = grant_data;
      exit_ch_d = grant_idx;
      if (mode) begin
        ptr_d = grant_idx;
      end
    end else if (exit_ready) begin
      slot_d = EMPTY;
    end
  end

  // State registers; ptr resets to CH-1 so channel 0 has first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= EMPTY;
      exit_q    <= '0;
      exit_ch_q <= '0;
      ptr_q     <= SELW'(CH - 1);
    end else begin
      slot_q    <= slot_d;
      exit_q    <= exit_d;
      exit_ch_q <= exit_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign exit       = exit_q;
  assign exit_valid = (slot_q == FULL);
  assign exit_ch    = exit_ch_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Testbench for mux_stream_rr: per-cycle behavioural model plus directed
// literal checks, then randomized traffic; a second CH=5 instance covers
// non-power-of-two wrap and out-of-range select.
module tb_mux_stream_rr;

  localparam int unsigned N   = 4;
  localparam int unsigned CH  = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned CH5 = 5;

  logic            clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [CH*N-1:0] d;
  logic [CH-1:0]   valid_in;
  logic [CH-1:0]   ready_in;
  logic            mode;
  logic [SW-1:0]   select;
  logic [N-1:0]    exit;
  logic            exit_valid;
  logic            exit_ready;
  logic [SW-1:0]   exit_ch;

  logic             r5;
  logic [CH5*N-1:0] d5;
  logic [CH5-1:0]   v5;
  logic [CH5-1:0]   rdy5;
  logic             mode5;
  logic [SW-1:0]    sel5;
  logic [N-1:0]     exit5;
  logic             ev5;
  logic             er5;
  logic [SW-1:0]    ech5;

  int checks   = 0;
  int failures = 0;

  mux_stream_rr #(.N(N), .CH(CH)) dut (
    .clk(clk), .reset(reset), .d(d), .valid_in(valid_in), .ready_in(ready_in),
    .mode(mode), .select(select), .exit(exit), .exit_valid(exit_valid),
    .exit_ready(exit_ready), .exit_ch(exit_ch)
  );

  mux_stream_rr #(.N(N), .CH(CH5)) dut5 (
    .clk(clk), .reset(r5), .d(d5), .valid_in(v5), .ready_in(rdy5),
    .mode(mode5), .select(sel5), .exit(exit5), .exit_valid(ev5),
    .exit_ready(er5), .exit_ch(ech5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: at each falling edge compare outputs with the model,
  // predict ready_in from current inputs, then advance the model past the next rising edge.
  initial begin : model
    bit            mvalid;
    bit            mfull;
    logic [N-1:0]  mdata;
    int            mch;
    int            mptr;
    int            g;
    bit            gv;
    bit            ld;
    logic [CH-1:0] exp_r;
    mvalid = 0; mfull = 0; mdata = '0; mch = 0; mptr = CH - 1;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("m_exit_valid", 32'(exit_valid), 32'(mfull));
        if (mfull) begin
          chk("m_exit", 32'(exit), 32'(mdata));
          chk("m_exit_ch", 32'(exit_ch), mch);
        end
      end
      gv = 0;
      g  = 0;
      if (reset !== 1'b1) begin
        if (mode == 1'b0) begin
          if (int'(select) < CH && valid_in[select]) begin
            gv = 1;
            g  = int'(select);
          end
        end else begin
          for (int i = 1; i <= CH; i++) begin
            if (!gv && valid_in[(mptr + i) % CH]) begin
              gv = 1;
              g  = (mptr + i) % CH;
            end
          end
        end
      end
      ld    = !mfull || exit_ready;
      exp_r = '0;
      if (gv && ld) exp_r = CH'(1) << g;
      if (mvalid || reset === 1'b1) chk("m_ready_in", 32'(ready_in), 32'(exp_r));
      if (reset === 1'b1) begin
        mfull = 0; mdata = '0; mch = 0; mptr = CH - 1; mvalid = 1;
      end else if (gv && ld) begin
        mfull = 1;
        mdata = d[g*N +: N];
        mch   = g;
        if (mode) mptr = g;
      end else if (exit_ready) begin
        mfull = 0;
      end
    end
  end

  initial begin : stim
    int seq8[6];
    int seq5[6];
    seq8 = '{0, 2, 7, 0, 2, 7};
    seq5 = '{0, 1, 2, 3, 4, 0};

    reset = 1'b1; valid_in = '1; mode = 1'b1; select = '0; exit_ready = 1'b1; d = $urandom;
    r5 = 1'b1; v5 = '0; mode5 = 1'b0; sel5 = '0; er5 = 1'b0; d5 = '0;

    // Reset and idle
    cyc(); cyc();
    chk("rst_ready_in", 32'(ready_in), 0);
    chk("rst_exit_valid", 32'(exit_valid), 0);
    chk("rst_exit", 32'(exit), 0);
    chk("rst_exit_ch", 32'(exit_ch), 0);
    reset = 1'b0;
    cyc();
    chk("rst_first_ch", 32'(exit_ch), 0);
    chk("rst_first_valid", 32'(exit_valid), 1);

    // Fixed select
    mode = 1'b0; select = 3'd5; d[5*N +: N] = 4'hA; valid_in = '1; exit_ready = 1'b1;
    #1;
    chk("fix_ready_in", 32'(ready_in), 32'h20);
    cyc();
    chk("fix_exit", 32'(exit), 32'hA);
    chk("fix_exit_ch", 32'(exit_ch), 5);
    valid_in[5] = 1'b0;
    #1;
    chk("fix_noval_ready", 32'(ready_in), 0);
    cyc();
    chk("fix_noval_drain", 32'(exit_valid), 0);

    // Round-robin wrap
    reset = 1'b1;
    cyc();
    reset = 1'b0; mode = 1'b1; valid_in = 8'b1000_0101;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_wrap_ch", 32'(exit_ch), seq8[i]);
    end

    // Backpressure (ptr is 7 here; mode-0 accept must not move it)
    mode = 1'b0; select = 3'd1; d[1*N +: N] = 4'h3; valid_in = '1; exit_ready = 1'b1;
    cyc();
    chk("bp_load_exit", 32'(exit), 32'h3);
    exit_ready = 1'b0; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in = 8'($urandom);
      d = $urandom;
      #1;
      chk("bp_ready_in", 32'(ready_in), 0);
      cyc();
      chk("bp_exit", 32'(exit), 32'h3);
      chk("bp_exit_ch", 32'(exit_ch), 1);
      chk("bp_exit_valid", 32'(exit_valid), 1);
    end
    exit_ready = 1'b1; valid_in = '1;
    cyc();
    chk("bp_ptr_kept", 32'(exit_ch), 0);

    // Simultaneous drain and load
    valid_in = 8'h08;
    #1;
    chk("dl_ready_in", 32'(ready_in), 32'h08);
    cyc();
    chk("dl_exit_valid", 32'(exit_valid), 1);
    chk("dl_exit_ch", 32'(exit_ch), 3);
    valid_in = '0;
    cyc();
    chk("dl_drain_empty", 32'(exit_valid), 0);

    // Reset mid-stream with ptr=4
    valid_in = 8'h10;
    cyc();
    chk("mid_load_ch", 32'(exit_ch), 4);
    reset = 1'b1; valid_in = '1;
    cyc();
    chk("mid_rst_valid", 32'(exit_valid), 0);
    reset = 1'b0;
    cyc();
    chk("mid_rst_ch", 32'(exit_ch), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      valid_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      select     = 3'($urandom);
      exit_ready = ($urandom_range(0, 9) < 7);
      d          = $urandom;
      cyc();
    end
    reset = 1'b0;

    // CH=5: non-power-of-two wrap and out-of-range select
    cyc();
    r5 = 1'b0; mode5 = 1'b1; v5 = '1; er5 = 1'b1; d5 = 20'($urandom);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ch5_rr_ch", 32'(ech5), seq5[i]);
    end
    mode5 = 1'b0; sel5 = 3'd6;
    #1;
    chk("ch5_sel_oor", 32'(rdy5), 0);
    sel5 = 3'd4;
    #1;
    chk("ch5_sel4", 32'(rdy5), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Registered, parametrised stream multiplexer: selects one of `CH` input channels of `N`-bit data and forwards it through a single output register stage using valid/ready handshakes. It supports a fixed-select mode, which keeps the `select`-port behaviour of the combinational muxes, and a fair round-robin arbitration mode. It sits between producer datapath stages and a shared consumer, such as a register-file write port or an ALU operand bus.

## Interface
- `N`, default 4: data width per channel, ≥1.
- `CH`, default 8: number of input channels, ≥2; need not be a power of two.
- `SELW`, default `$clog2(CH)`: derived select/channel-index width; never overridden.
- `clk`  input  1: single clock, rising-edge.
- `reset`  input  1: synchronous, active-high reset.
- `d`  input  CH*N: flattened channel data; channel k occupies `d[k*N +: N]`.
- `valid_in`  input  CH: per-channel valid.
- `ready_in`  output  CH: per-channel ready, one-hot or zero.
- `mode`  input  1: 0 = fixed select, 1 = round-robin.
- `select`  input  SELW: channel index used in mode 0; ignored in mode 1.
- `exit`  output  N: registered output data.
- `exit_valid`  output  1: output register holds a beat.
- `exit_ready`  input  1: consumer accepts the beat.
- `exit_ch`  output  SELW: index of the channel that sourced the current `exit` beat.

## Operation
- Output slot, two states:
  - EMPTY: `exit_valid`=0.
  - FULL: `exit_valid`=1.
- `load` = `!exit_valid | exit_ready`: the slot can take a new beat this cycle.
- Grant, combinational, at most one channel:
  - Mode 0: grant `select` iff `select < CH` and `valid_in[select]`. If `select ≥ CH`, nothing is granted.
  - Mode 1: scan channels `ptr+1, ptr+2, …` modulo CH, wrapping past CH-1 to 0. Grant the first channel with `valid_in` set.
- `ready_in[g]` = `load & grant_valid` for the granted g only; all other bits are 0.
- Accept occurs when a grant exists and `load`=1. On accept:
  - `exit` ← `d[g]`.
  - `exit_ch` ← g.
  - Slot goes to FULL.
  - In mode 1, `ptr` ← g.
- Slot transitions:
  - Consumer drains (`exit_valid & exit_ready`) with no accept in the same cycle: slot goes to EMPTY.
  - Drain and accept in the same cycle: slot stays FULL with the new beat (full throughput).
  - FULL and `exit_ready`=0: `exit`, `exit_ch` and `exit_valid` hold stable. All `ready_in` are 0.
- `ptr` changes only on accepts in mode 1. Mode-0 accepts leave `ptr` untouched.
- A change of `mode` or `select` affects only the grant computed in that cycle. It never alters a beat already in the output register.
- Inputs with `valid_in`=0 are never granted, in either mode. Upstream may drop `valid_in` at any time; the design does not depend on valid stability.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge):
  - `exit_valid`=0, `exit`=0, `exit_ch`=0.
  - `ptr`=CH-1, so channel 0 has first priority after reset.
- While `reset`=1, `ready_in`=0 and no accept occurs. Any in-flight beat is discarded.
- Latency: an accept at edge t makes the beat visible on `exit` with `exit_valid`=1 immediately after edge t, i.e. one cycle.
- Throughput: one beat per cycle while `exit_ready`=1 and any grant exists.
- Combinational paths:
  - `exit_ready` → `ready_in`.
  - `valid_in`, `mode` and `select` → `ready_in`.
  - There is no path from any input to `exit`, `exit_valid` or `exit_ch`.
- Round-robin fairness: with all CH channels continuously valid and `exit_ready`=1, each channel is granted exactly once in every CH consecutive accepts.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset` 2 cycles with all `valid_in`=1.
  - Response: `exit_valid`=0, `exit`=0, `exit_ch`=0, `ready_in`=0. After release in mode 1 with all valid, the first accepted beat has `exit_ch`=0.
- Fixed select:
  - Stimulus: `N`=4, `CH`=8, mode 0, `select`=5, `d[5]`=4'hA, `valid_in`=8'hFF, `exit_ready`=1.
  - Response: `ready_in`=8'h20. Next cycle `exit`=4'hA, `exit_ch`=5.
  - Also: `select`=5 with `valid_in[5]`=0 gives `ready_in`=0 and no accept.
- Round-robin wrap:
  - Stimulus: mode 1, `valid_in`=8'b1000_0101, `exit_ready`=1.
  - Response: grant sequence 0, 2, 7, 0, 2, 7, …
  - Variant: with `CH`=5 and all valid, the grant sequence is 0, 1, 2, 3, 4, 0.
- Backpressure:
  - Stimulus: slot FULL with `exit`=4'h3, `exit_ready`=0 for 4 cycles while channels toggle.
  - Response: `exit`, `exit_ch` and `exit_valid` stay stable. `ready_in`=0 throughout. `ptr` is unchanged.
- Simultaneous drain and load:
  - Stimulus: slot FULL, `exit_ready`=1, channel 3 valid.
  - Response: in the same cycle `ready_in[3]`=1, and next cycle `exit_valid` stays 1 with `exit_ch`=3. No bubble.
  - Also: drain with no valid inputs leaves the slot EMPTY.
- Reset mid-stream:
  - Stimulus: assert `reset` for 1 cycle while FULL, in mode 1, with `ptr`=4.
  - Response: `exit_valid`=0 next cycle. `ptr`=7, so the next round-robin grant starts at channel 0.
